// File: rtl/accel_spi_pkg.sv
// Shared constants for the accelerometer SPI responder: command codes, ID bytes,
// register addresses, writable window bounds and FSM state encodings.
package accel_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ID_0 = 8'hAD;
  localparam logic [7:0] ID_1 = 8'h1D;
  localparam logic [7:0] ID_2 = 8'hF2;
  localparam logic [7:0] ID_3 = 8'h01;

  localparam logic [5:0] ADDR_ID0 = 6'h00;
  localparam logic [5:0] ADDR_ID1 = 6'h01;
  localparam logic [5:0] ADDR_ID2 = 6'h02;
  localparam logic [5:0] ADDR_ID3 = 6'h03;
  localparam logic [5:0] ADDR_X8  = 6'h08;
  localparam logic [5:0] ADDR_Y8  = 6'h09;
  localparam logic [5:0] ADDR_Z8  = 6'h0A;
  localparam logic [5:0] ADDR_XL  = 6'h0E;
  localparam logic [5:0] ADDR_XH  = 6'h0F;
  localparam logic [5:0] ADDR_YL  = 6'h10;
  localparam logic [5:0] ADDR_YH  = 6'h11;
  localparam logic [5:0] ADDR_ZL  = 6'h12;
  localparam logic [5:0] ADDR_ZH  = 6'h13;

  localparam logic [5:0] WR_LO       = 6'h1F;
  localparam logic [5:0] WR_HI       = 6'h2E;
  localparam int         STORE_DEPTH = 16;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_WR     = 3'd3;
  localparam state_t ST_RD     = 3'd4;
  localparam state_t ST_IGNORE = 3'd5;

  // Upper sample byte: sign-extend bits [11:8] into a full byte.
  function automatic logic [7:0] hi_byte(input logic [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

  function automatic logic is_writable(input logic [5:0] a);
    return (a >= WR_LO) && (a <= WR_HI);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversamples SCLK/CS/MOSI into the system clock domain and produces registered
// one-cycle SCLK rise/fall pulses with CS/MOSI levels aligned to them.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   cs_q;
  logic                   mosi_q;

  // cs resets to 0 ("selected"): the responder must actually observe cs high
  // after reset before it will accept a new transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cs_q        <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      fall_q      <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
      cs_q        <= cs_sync_q[SYNC_STAGES-1];
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o = rise_q;
  assign sclk_fall_o = fall_q;
  assign cs_o        = cs_q;
  assign mosi_o      = mosi_q;

endmodule

// File: rtl/accel_spi_responder.sv
// Device-side SPI (mode 0, MSB first) model of the accelerometer register protocol:
// ID/sample reads, writable storage window, coherent sample snapshots.
module accel_spi_responder
  import accel_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  input  logic [11:0] accel_z,
  input  logic        sample_valid,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_s;
  logic mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (sclk),
    .cs_i        (cs),
    .mosi_i      (mosi),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_o        (cs_s),
    .mosi_o      (mosi_s)
  );

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        load_q, load_d;
  logic        is_wr_q, is_wr_d;
  logic        wait_cs_q, wait_cs_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        store_we;
  logic [3:0]  store_idx;
  logic [7:0]  storage_q [STORE_DEPTH];

  logic [11:0] sx_q, sy_q, sz_q;
  logic [11:0] px_q, py_q, pz_q;
  logic        pend_q;

  logic        byte_done;
  logic [7:0]  byte_val;
  logic [7:0]  rd_data;

  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign byte_val  = {shift_q, mosi_s};
  // Window 0x1F..0x2E maps onto index 0..15 using the low nibble alone.
  assign store_idx = addr_q[3:0] - WR_LO[3:0];

  always_comb begin
    rd_data = 8'h00;
    case (addr_q)
      ADDR_ID0: rd_data = ID_0;
      ADDR_ID1: rd_data = ID_1;
      ADDR_ID2: rd_data = ID_2;
      ADDR_ID3: rd_data = ID_3;
      ADDR_X8:  rd_data = sx_q[11:4];
      ADDR_Y8:  rd_data = sy_q[11:4];
      ADDR_Z8:  rd_data = sz_q[11:4];
      ADDR_XL:  rd_data = sx_q[7:0];
      ADDR_XH:  rd_data = hi_byte(sx_q);
      ADDR_YL:  rd_data = sy_q[7:0];
      ADDR_YH:  rd_data = hi_byte(sy_q);
      ADDR_ZL:  rd_data = sz_q[7:0];
      ADDR_ZH:  rd_data = hi_byte(sz_q);
      default:  rd_data = is_writable(addr_q) ? storage_q[store_idx] : 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    load_d      = load_q;
    is_wr_d     = is_wr_q;
    wait_cs_d   = wait_cs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    store_we    = 1'b0;

    if (cs_s) begin
      // Deselect wins over everything: partial bytes are dropped.
      wait_cs_d = 1'b0;
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      load_d    = 1'b0;
    end else begin
      if (sclk_rise) begin
        shift_d   = {shift_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
          if (!wait_cs_q) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (byte_done) begin
            case (byte_val)
              CMD_WRITE: begin state_d = ST_ADDR; is_wr_d = 1'b1; end
              CMD_READ:  begin state_d = ST_ADDR; is_wr_d = 1'b0; end
              default:   state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            addr_d  = byte_val[5:0];
            state_d = is_wr_q ? ST_WR : ST_RD;
            load_d  = !is_wr_q;
          end
        end
        ST_WR: begin
          if (byte_done) begin
            addr_d = addr_q + 6'd1;
            if (is_writable(addr_q)) begin
              store_we    = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = byte_val;
            end
          end
        end
        ST_RD: begin
          if (byte_done) load_d = 1'b1;
          if (sclk_fall) begin
            if (load_q) begin
              tx_d   = {rd_data[6:0], 1'b0};
              miso_d = rd_data[7];
              addr_d = addr_q + 6'd1;
              load_d = 1'b0;
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
        ST_IGNORE: miso_d = 1'b0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      addr_q      <= 6'd0;
      tx_q        <= 8'd0;
      miso_q      <= 1'b0;
      load_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      wait_cs_q   <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      load_q      <= load_d;
      is_wr_q     <= is_wr_d;
      wait_cs_q   <= wait_cs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STORE_DEPTH; i++) storage_q[i] <= 8'h00;
    end else if (store_we) begin
      storage_q[store_idx] <= byte_val;
    end
  end

  // Samples only change while idle so a burst read sees one coherent snapshot;
  // a fresh strobe in the idle cycle supersedes anything pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q   <= '0;
      sy_q   <= '0;
      sz_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
      pz_q   <= '0;
      pend_q <= 1'b0;
    end else if (!busy) begin
      if (sample_valid) begin
        sx_q   <= accel_x;
        sy_q   <= accel_y;
        sz_q   <= accel_z;
        pend_q <= 1'b0;
      end else if (pend_q) begin
        sx_q   <= px_q;
        sy_q   <= py_q;
        sz_q   <= pz_q;
        pend_q <= 1'b0;
      end
    end else if (sample_valid) begin
      px_q   <= accel_x;
      py_q   <= accel_y;
      pz_q   <= accel_z;
      pend_q <= 1'b1;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign miso        = miso_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Directed bench for accel_spi_responder: an SPI master model drives register
// reads/writes, aborts and snapshot cases against hand-computed expectations.
module tb_accel_spi_responder;

  localparam int H = 8;  // sclk half period in clk cycles (sclk = clk/16)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IGNORE = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] accel_x = '0;
  logic [11:0] accel_y = '0;
  logic [11:0] accel_z = '0;
  logic        sample_valid = 1'b0;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  int         strobe_cnt = 0;
  logic [5:0] last_addr = '0;
  logic [7:0] last_data = '0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_buf [0:7];

  accel_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .sample_valid (sample_valid),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_begin();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (H) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [5:0] addr, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_bits(cmd, 8, rx);
    spi_bits({2'b00, addr}, 8, rx);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      rx_buf[i] = rx;
    end
    spi_end();
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits({2'b00, addr}, 8, rx);
    spi_bits(d0, 8, rx);
    if (n > 1) spi_bits(d1, 8, rx);
    spi_end();
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    accel_x = x;
    accel_y = y;
    accel_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (H) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    total++; if (wr_addr !== 6'h00) begin bad++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_id_read();
    logic [7:0] e;
    exp_q = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
    do_read(8'h0B, 6'h00, 4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      total++;
      if (rx_buf[i] !== e) begin bad++; $display("FAIL id_read[%0d]: got %h want %h", i, rx_buf[i], e); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL id_read_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_sample_read();
    logic [7:0] e;
    pulse_sample(12'hF85, 12'h123, 12'h800);
    exp_q = '{8'h85, 8'hFF, 8'h23, 8'h01, 8'h00, 8'hF8};
    do_read(8'h0B, 6'h0E, 6);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      total++;
      if (rx_buf[i] !== e) begin bad++; $display("FAIL sample_read[%0d]: got %h want %h", i, rx_buf[i], e); end
    end
    exp_q = '{8'hF8, 8'h12, 8'h80};
    do_read(8'h0B, 6'h08, 3);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++;
      if (rx_buf[i] !== e) begin bad++; $display("FAIL sample_hi8[%0d]: got %h want %h", i, rx_buf[i], e); end
    end
  endtask

  task automatic test_write();
    int base;
    base = strobe_cnt;
    do_write(6'h2E, 8'h55, 8'h66, 2);
    total++; if (strobe_cnt - base !== 1) begin bad++; $display("FAIL write_top_strobes: got %0d want 1", strobe_cnt - base); end
    total++; if (last_addr !== 6'h2E) begin bad++; $display("FAIL write_top_addr: got %h want 2e", last_addr); end
    total++; if (last_data !== 8'h55) begin bad++; $display("FAIL write_top_data: got %h want 55", last_data); end
    do_read(8'h0B, 6'h2E, 2);
    total++; if (rx_buf[0] !== 8'h55) begin bad++; $display("FAIL read_2e: got %h want 55", rx_buf[0]); end
    total++; if (rx_buf[1] !== 8'h00) begin bad++; $display("FAIL read_2f: got %h want 00", rx_buf[1]); end
    base = strobe_cnt;
    do_write(6'h1F, 8'h11, 8'h00, 1);
    total++; if (strobe_cnt - base !== 1) begin bad++; $display("FAIL write_bot_strobes: got %0d want 1", strobe_cnt - base); end
    total++; if (last_addr !== 6'h1F) begin bad++; $display("FAIL write_bot_addr: got %h want 1f", last_addr); end
    do_read(8'h0B, 6'h1E, 2);
    total++; if (rx_buf[0] !== 8'h00) begin bad++; $display("FAIL read_1e: got %h want 00", rx_buf[0]); end
    total++; if (rx_buf[1] !== 8'h11) begin bad++; $display("FAIL read_1f: got %h want 11", rx_buf[1]); end
  endtask

  task automatic test_write_readonly();
    int base;
    base = strobe_cnt;
    do_write(6'h00, 8'h77, 8'h00, 1);
    total++; if (strobe_cnt !== base) begin bad++; $display("FAIL ro_write_strobes: got %0d want 0", strobe_cnt - base); end
    do_read(8'h0B, 6'h00, 1);
    total++; if (rx_buf[0] !== 8'hAD) begin bad++; $display("FAIL ro_read_00: got %h want ad", rx_buf[0]); end
    do_read(8'h0B, 6'h3F, 2);
    total++; if (rx_buf[0] !== 8'h00) begin bad++; $display("FAIL read_3f: got %h want 00", rx_buf[0]); end
    total++; if (rx_buf[1] !== 8'hAD) begin bad++; $display("FAIL wrap_to_00: got %h want ad", rx_buf[1]); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int base;
    base = strobe_cnt;
    spi_begin();
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h99, 5, rx);
    spi_end();
    total++; if (strobe_cnt !== base) begin bad++; $display("FAIL abort_strobes: got %0d want 0", strobe_cnt - base); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", dbg_state, S_IDLE); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL abort_miso: got %b want 0", miso); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    do_read(8'h0B, 6'h20, 1);
    total++; if (rx_buf[0] !== 8'h00) begin bad++; $display("FAIL abort_read_20: got %h want 00", rx_buf[0]); end
  endtask

  task automatic test_ignore();
    logic [7:0] rx;
    int base;
    base = strobe_cnt;
    spi_begin();
    spi_bits(8'h3C, 8, rx);
    total++; if (dbg_state !== S_IGNORE) begin bad++; $display("FAIL ignore_state: got %0d want %0d", dbg_state, S_IGNORE); end
    spi_bits(8'h1F, 8, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL ignore_miso_addr: got %h want 00", rx); end
    spi_bits(8'h99, 8, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL ignore_miso_data: got %h want 00", rx); end
    spi_end();
    total++; if (strobe_cnt !== base) begin bad++; $display("FAIL ignore_strobes: got %0d want 0", strobe_cnt - base); end
    do_read(8'h0B, 6'h1F, 1);
    total++; if (rx_buf[0] !== 8'h11) begin bad++; $display("FAIL ignore_read_1f: got %h want 11", rx_buf[0]); end
  endtask

  task automatic test_snapshot_burst();
    logic [7:0] rx;
    logic [7:0] e;
    // samples currently x=F85 y=123 z=800
    exp_q = '{8'h85, 8'hFF, 8'h23, 8'h01, 8'h00, 8'hF8};
    spi_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h0E, 8, rx);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        pulse_sample(12'h111, 12'h222, 12'h333);
        pulse_sample(12'h7FF, 12'h001, 12'hABC);
      end
      spi_bits(8'h00, 8, rx);
      e = exp_q.pop_front();
      total++;
      if (rx !== e) begin bad++; $display("FAIL snap_old[%0d]: got %h want %h", i, rx, e); end
    end
    spi_end();
    exp_q = '{8'hFF, 8'h07, 8'h01, 8'h00, 8'hBC, 8'hFA};
    do_read(8'h0B, 6'h0E, 6);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      total++;
      if (rx_buf[i] !== e) begin bad++; $display("FAIL snap_new[%0d]: got %h want %h", i, rx_buf[i], e); end
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] rx;
    spi_begin();
    spi_bits(8'h0B, 8, rx);
    spi_bits(8'h00, 8, rx);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h00) begin bad++; $display("FAIL rst_mid_miso: got %h want 00", rx); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, S_IDLE); end
    spi_end();
    do_read(8'h0B, 6'h01, 1);
    total++; if (rx_buf[0] !== 8'h1D) begin bad++; $display("FAIL rst_recover_read: got %h want 1d", rx_buf[0]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_id_read();
    test_sample_read();
    test_write();
    test_write_readonly();
    test_abort();
    test_ignore();
    test_snapshot_burst();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
